// File: rtl/ctrl_pipe_regs.sv
// Purpose: carries the decoded control word, valid, invalid flag and dst GPR through STAGES
//          pipeline registers, with hazard lookup and a retired-instruction counter.
// Latency: one cycle per stage (D-stage word is in stage k after edge n+k). Hit is combinational.
// Backpressure: stall[k] holds stage k; with AUTO_BUBBLE a stage whose upstream is held loads a bubble.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall_src          D stage held this cycle (upstream hold of stage 0)
//   stall/flush        per-stage hold / bubble-load requests (flush wins)
//   sig_in, valid_in, invalid_in, dst_in   D-stage control word and tags
//   sig_out, valid_out, invalid_out, dst_out   per-stage contents, stage k at [k*W +: W] / [k*5 +: 5]
//   query_reg, hit     hit[k]: stage k holds a valid GPR write to query_reg (never for $0)
//   retire_cnt         valid words that left the last stage, wraps modulo 2^CNT_W
module ctrl_pipe_regs #(
    parameter int W           = 14,
    parameter int STAGES      = 3,
    parameter int REGWR_BIT   = 6,
    parameter int AUTO_BUBBLE = 1,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_src,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    input  logic [W-1:0]          sig_in,
    input  logic                  valid_in,
    input  logic                  invalid_in,
    input  logic [4:0]            dst_in,
    output logic [STAGES*W-1:0]   sig_out,
    output logic [STAGES-1:0]     valid_out,
    output logic [STAGES-1:0]     invalid_out,
    output logic [STAGES*5-1:0]   dst_out,
    input  logic [4:0]            query_reg,
    output logic [STAGES-1:0]     hit,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam int LAST = STAGES - 1;

    logic [W-1:0] sig_q     [STAGES];
    logic [W-1:0] sig_d     [STAGES];
    logic [4:0]   dst_q     [STAGES];
    logic [4:0]   dst_d     [STAGES];
    logic         valid_q   [STAGES];
    logic         valid_d   [STAGES];
    logic         invalid_q [STAGES];
    logic         invalid_d [STAGES];

    // Fields presented to each stage's load path and the hold state of its source.
    logic [W-1:0] up_sig     [STAGES];
    logic [4:0]   up_dst     [STAGES];
    logic         up_valid   [STAGES];
    logic         up_invalid [STAGES];
    logic         up_hold    [STAGES];

    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] retire_d;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_src
                // A non-instruction never carries a control word downstream.
                assign up_sig[k]     = valid_in ? sig_in : '0;
                assign up_dst[k]     = dst_in;
                assign up_valid[k]   = valid_in;
                assign up_invalid[k] = invalid_in;
                assign up_hold[k]    = stall_src;
            end else begin : g_chain
                assign up_sig[k]     = sig_q[k-1];
                assign up_dst[k]     = dst_q[k-1];
                assign up_valid[k]   = valid_q[k-1];
                assign up_invalid[k] = invalid_q[k-1];
                assign up_hold[k]    = stall[k-1];
            end

            always_comb begin
                sig_d[k]     = up_sig[k];
                dst_d[k]     = up_dst[k];
                valid_d[k]   = up_valid[k];
                invalid_d[k] = up_invalid[k];
                if (flush[k]) begin
                    sig_d[k]     = '0;
                    dst_d[k]     = '0;
                    valid_d[k]   = 1'b0;
                    invalid_d[k] = 1'b0;
                end else if (stall[k]) begin
                    sig_d[k]     = sig_q[k];
                    dst_d[k]     = dst_q[k];
                    valid_d[k]   = valid_q[k];
                    invalid_d[k] = invalid_q[k];
                end else if ((AUTO_BUBBLE != 0) && up_hold[k]) begin
                    // Upstream keeps its word, so copying it would duplicate the instruction.
                    sig_d[k]     = '0;
                    dst_d[k]     = '0;
                    valid_d[k]   = 1'b0;
                    invalid_d[k] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sig_q[k]     <= '0;
                    dst_q[k]     <= '0;
                    valid_q[k]   <= 1'b0;
                    invalid_q[k] <= 1'b0;
                end else begin
                    sig_q[k]     <= sig_d[k];
                    dst_q[k]     <= dst_d[k];
                    valid_q[k]   <= valid_d[k];
                    invalid_q[k] <= invalid_d[k];
                end
            end

            assign sig_out[k*W +: W] = sig_q[k];
            assign dst_out[k*5 +: 5] = dst_q[k];
            assign valid_out[k]      = valid_q[k];
            assign invalid_out[k]    = invalid_q[k];
            assign hit[k]            = valid_q[k] & sig_q[k][REGWR_BIT]
                                       & (dst_q[k] == query_reg) & (query_reg != 5'd0);
        end
    endgenerate

    // A word retires only when it actually leaves: a flushed or stalled last stage does not count.
    always_comb begin
        retire_d = retire_q;
        if (valid_q[LAST] && !stall[LAST] && !flush[LAST]) begin
            retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
module tb_ctrl_pipe_regs;

    localparam int W  = 14;
    localparam int S  = 3;
    localparam int CW = 4;

    logic           clk;
    logic           rst;
    logic           stall_src;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic [W-1:0]   sig_in;
    logic           valid_in;
    logic           invalid_in;
    logic [4:0]     dst_in;
    logic [S*W-1:0] sig_out;
    logic [S-1:0]   valid_out;
    logic [S-1:0]   invalid_out;
    logic [S*5-1:0] dst_out;
    logic [4:0]     query_reg;
    logic [S-1:0]   hit;
    logic [CW-1:0]  retire_cnt;

    int checks;
    int failures;

    ctrl_pipe_regs #(
        .W(W), .STAGES(S), .REGWR_BIT(6), .AUTO_BUBBLE(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall_src(stall_src), .stall(stall), .flush(flush),
        .sig_in(sig_in), .valid_in(valid_in), .invalid_in(invalid_in), .dst_in(dst_in),
        .sig_out(sig_out), .valid_out(valid_out), .invalid_out(invalid_out),
        .dst_out(dst_out), .query_reg(query_reg), .hit(hit), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then settled and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_src  = 1'b0;
        stall      = '0;
        flush      = '0;
        sig_in     = '0;
        valid_in   = 1'b0;
        invalid_in = 1'b0;
        dst_in     = '0;
        query_reg  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst      = 1'b1;
        valid_in = 1'b1;
        sig_in   = 14'h0060;
        dst_in   = 5'd5;
        step();
        step();
        checks++;
        if (sig_out !== '0 || valid_out !== '0 || dst_out !== '0 || invalid_out !== '0) begin
            failures++;
            $display("FAIL reset_regs: sig=%h valid=%b dst=%h inv=%b required all 0",
                     sig_out, valid_out, dst_out, invalid_out);
        end
        checks++;
        if (retire_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d required 0", retire_cnt);
        end
        rst    = 1'b0;
        sig_in = 14'h0123;
        dst_in = 5'd7;
        step();
        checks++;
        if (valid_out !== 3'b001 || sig_out[0 +: W] !== 14'h0123 || dst_out[0 +: 5] !== 5'd7) begin
            failures++;
            $display("FAIL reset_release: valid=%b sig0=%h dst0=%0d required 001 0123 7",
                     valid_out, sig_out[0 +: W], dst_out[0 +: 5]);
        end
    endtask

    task automatic test_stream();
        do_reset();
        sig_in    = 14'h0060;
        dst_in    = 5'd5;
        valid_in  = 1'b1;
        query_reg = 5'd5;
        step();
        valid_in = 1'b0;
        sig_in   = 14'h3fff;
        checks++;
        if (hit !== 3'b001) begin
            failures++;
            $display("FAIL stream_hit0: got %b required 001", hit);
        end
        step();
        checks++;
        if (hit !== 3'b010) begin
            failures++;
            $display("FAIL stream_hit1: got %b required 010", hit);
        end
        checks++;
        if (sig_out[0 +: W] !== 14'h0000 || valid_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL stream_invalid_zero: sig0=%h v0=%b required 0000 0",
                     sig_out[0 +: W], valid_out[0]);
        end
        step();
        checks++;
        if (sig_out[2*W +: W] !== 14'h0060 || hit !== 3'b100 || retire_cnt !== 4'd0) begin
            failures++;
            $display("FAIL stream_stage2: sig2=%h hit=%b cnt=%0d required 0060 100 0",
                     sig_out[2*W +: W], hit, retire_cnt);
        end
        step();
        checks++;
        if (retire_cnt !== 4'd1 || valid_out !== 3'b000 || hit !== 3'b000) begin
            failures++;
            $display("FAIL stream_retire: cnt=%0d valid=%b hit=%b required 1 000 000",
                     retire_cnt, valid_out, hit);
        end
    endtask

    task automatic test_stall_bubble();
        do_reset();
        sig_in   = 14'h0041;
        dst_in   = 5'd3;
        valid_in = 1'b1;
        step();
        sig_in    = 14'h0042;
        dst_in    = 5'd4;
        stall     = 3'b001;
        stall_src = 1'b1;
        step();
        checks++;
        if (valid_out !== 3'b001 || sig_out[0 +: W] !== 14'h0041 || sig_out[W +: W] !== 14'h0000) begin
            failures++;
            $display("FAIL stall_bubble: valid=%b sig0=%h sig1=%h required 001 0041 0000",
                     valid_out, sig_out[0 +: W], sig_out[W +: W]);
        end
        stall     = 3'b000;
        stall_src = 1'b0;
        step();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 3'b011 || sig_out[0 +: W] !== 14'h0042 || sig_out[W +: W] !== 14'h0041) begin
            failures++;
            $display("FAIL stall_resume: valid=%b sig0=%h sig1=%h required 011 0042 0041",
                     valid_out, sig_out[0 +: W], sig_out[W +: W]);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        sig_in    = 14'h0040;
        dst_in    = 5'd9;
        valid_in  = 1'b1;
        query_reg = 5'd9;
        step();
        valid_in = 1'b0;
        step();
        checks++;
        if (hit !== 3'b010) begin
            failures++;
            $display("FAIL flush_prehit: got %b required 010", hit);
        end
        flush = 3'b010;
        stall = 3'b010;
        step();
        flush = 3'b000;
        stall = 3'b000;
        checks++;
        if (valid_out !== 3'b000 || hit !== 3'b000 || dst_out[5 +: 5] !== 5'd0 || sig_out[W +: W] !== 14'h0000) begin
            failures++;
            $display("FAIL flush_over_stall: valid=%b hit=%b dst1=%0d sig1=%h required 000 000 0 0000",
                     valid_out, hit, dst_out[5 +: 5], sig_out[W +: W]);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        sig_in    = 14'h0040;
        dst_in    = 5'd0;
        valid_in  = 1'b1;
        query_reg = 5'd0;
        step();
        checks++;
        if (valid_out !== 3'b001 || hit !== 3'b000) begin
            failures++;
            $display("FAIL zero_reg: valid=%b hit=%b required 001 000", valid_out, hit);
        end
        sig_in    = 14'h0001;
        dst_in    = 5'd5;
        query_reg = 5'd5;
        step();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 3'b011 || hit !== 3'b000) begin
            failures++;
            $display("FAIL no_regwr: valid=%b hit=%b required 011 000", valid_out, hit);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        sig_in     = 14'h0002;
        valid_in   = 1'b1;
        invalid_in = 1'b1;
        step();
        valid_in   = 1'b0;
        invalid_in = 1'b0;
        checks++;
        if (invalid_out !== 3'b001) begin
            failures++;
            $display("FAIL invalid_s0: got %b required 001", invalid_out);
        end
        step();
        checks++;
        if (invalid_out !== 3'b010) begin
            failures++;
            $display("FAIL invalid_s1: got %b required 010", invalid_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        sig_in   = 14'h0040;
        dst_in   = 5'd1;
        valid_in = 1'b1;
        for (int i = 0; i < 17; i++) step();
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (retire_cnt !== 4'd1) begin
            failures++;
            $display("FAIL wrap_cnt: got %0d required 1", retire_cnt);
        end
        // Stalled last stage must not count until the word really leaves.
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        step();
        stall = 3'b100;
        step();
        checks++;
        if (retire_cnt !== 4'd1 || valid_out[2] !== 1'b1) begin
            failures++;
            $display("FAIL stall_last: cnt=%0d v2=%b required 1 1", retire_cnt, valid_out[2]);
        end
        stall = 3'b000;
        step();
        checks++;
        if (retire_cnt !== 4'd2) begin
            failures++;
            $display("FAIL stall_last_release: got %0d required 2", retire_cnt);
        end
        // Flushing the last stage discards the word without retiring it.
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        step();
        flush = 3'b100;
        step();
        flush = 3'b000;
        checks++;
        if (retire_cnt !== 4'd2 || valid_out !== 3'b000) begin
            failures++;
            $display("FAIL flush_last: cnt=%0d valid=%b required 2 000", retire_cnt, valid_out);
        end
        step();
        checks++;
        if (retire_cnt !== 4'd2) begin
            failures++;
            $display("FAIL flush_last_after: got %0d required 2", retire_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_stall_bubble();
        test_flush_stall();
        test_zero_reg();
        test_invalid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
